// File: rtl/tpumac_pipe.sv
// rtl/tpumac_pipe.sv - systolic-array MAC cell with optional multiplier pipeline and saturating accumulator
//
// Purpose:
//   One cell of an NxN systolic grid. A, B and a valid bit are forwarded to the
//   neighbouring cells through one register stage. Valid operand pairs are
//   multiplied and accumulated into the local C register. The product can be
//   registered first (MULT_PIPE=1). The accumulator either clamps or wraps on
//   overflow (SATURATE). A sticky flag records every overflow until it is cleared.
//
// Parameters:
//   BITS_AB   signed operand width of A and B
//   BITS_C    signed accumulator width, must be >= 2*BITS_AB
//   MULT_PIPE 0: product feeds the adder directly, 1: product is registered first
//   SATURATE  1: clamp on overflow, 0: two's-complement wrap
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     global enable; 0 freezes every register
//   WrEn   load Cin into the accumulator (preload / systolic readout)
//   clr    synchronous clear of the accumulator, the overflow flag and the pipeline
//   vin    Ain/Bin carry a real operand pair
//   Ain    signed operand A
//   Bin    signed operand B
//   Cin    signed preload / shift-in value
//   Aout   registered Ain
//   Bout   registered Bin
//   vout   registered vin, travels with Aout
//   Cout   signed accumulator
//   ovf    sticky overflow flag

module tpumac_pipe #(
  parameter int BITS_AB   = 8,
  parameter int BITS_C    = 16,
  parameter int MULT_PIPE = 1,
  parameter int SATURATE  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic                      clr,
  input  logic                      vin,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic                      vout,
  output logic signed [BITS_C-1:0]  Cout,
  output logic                      ovf
);

  // Full-width product and the one-bit-wider sum used for overflow detection.
  localparam int PW = 2 * BITS_AB;
  localparam int SW = BITS_C + 1;

  localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  // The product must always fit in the accumulator. This is what keeps
  // (-2^(BITS_AB-1))^2 free of any product-level clamp.
  generate
    if (BITS_C < PW) begin : g_width_check
      $error("tpumac_pipe: BITS_C must be >= 2*BITS_AB");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Operand / valid forwarding to the neighbouring cells.
  // clr and WrEn have no effect here; only en gates the shift.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Aout <= '0;
      Bout <= '0;
      vout <= 1'b0;
    end else if (en) begin
      Aout <= Ain;
      Bout <= Bin;
      vout <= vin;
    end
  end

  // --------------------------------------------------------------------------
  // Multiplier, optionally followed by a register stage
  // --------------------------------------------------------------------------
  logic signed [PW-1:0] prod_now;
  logic signed [PW-1:0] add_prod;
  logic                 add_vld;

  // The assignment context is PW bits wide, so both signed operands are
  // extended before the multiply and the full product is kept.
  assign prod_now = Ain * Bin;

  generate
    if (MULT_PIPE != 0) begin : g_mult_pipe
      logic signed [PW-1:0] p_q;
      logic                 pv_q;

      // P and pv capture every enabled cycle, even while WrEn is loading C.
      // clr kills only the valid bit; the stale P value is never used.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_q  <= '0;
          pv_q <= 1'b0;
        end else if (en) begin
          p_q  <= prod_now;
          pv_q <= clr ? 1'b0 : vin;
        end
      end

      assign add_prod = p_q;
      assign add_vld  = pv_q;
    end else begin : g_mult_comb
      assign add_prod = prod_now;
      assign add_vld  = vin;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Accumulate: sign-extend both terms by one bit. If the result's top two
  // bits differ, the value does not fit in BITS_C.
  // --------------------------------------------------------------------------
  logic signed [SW-1:0]     acc_ext;
  logic signed [SW-1:0]     prod_ext;
  logic signed [SW-1:0]     sum;
  logic                     sum_ovf;
  logic        [BITS_C-1:0] sum_res;

  assign acc_ext  = {Cout[BITS_C-1], Cout};
  assign prod_ext = {{(SW-PW){add_prod[PW-1]}}, add_prod};
  assign sum      = acc_ext + prod_ext;
  assign sum_ovf  = sum[SW-1] ^ sum[SW-2];

  generate
    if (SATURATE != 0) begin : g_sat
      // The true sign of the sum is bit SW-1; clamp towards it.
      assign sum_res = sum_ovf ? (sum[SW-1] ? C_MIN : C_MAX) : sum[BITS_C-1:0];
    end else begin : g_wrap
      assign sum_res = sum[BITS_C-1:0];
    end
  endgenerate

  // Next-state selection. Priority: clr, then WrEn, then a valid product.
  logic [BITS_C-1:0] c_next;
  logic              ovf_next;

  always_comb begin
    c_next   = Cout;
    ovf_next = ovf;
    if (clr) begin
      c_next   = '0;
      ovf_next = 1'b0;
    end else if (WrEn) begin
      // Any product arriving this edge is dropped in favour of the preload.
      c_next   = Cin;
      ovf_next = 1'b0;
    end else if (add_vld) begin
      c_next   = sum_res;
      ovf_next = ovf | sum_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Cout <= '0;
      ovf  <= 1'b0;
    end else if (en) begin
      Cout <= c_next;
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_tpumac_pipe.sv
// tb/tb_tpumac_pipe.sv - directed self-checking bench for tpumac_pipe

module tb_tpumac_pipe;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              WrEn;
  logic              clr;
  logic              vin;
  logic signed [7:0]  Ain;
  logic signed [7:0]  Bin;
  logic signed [15:0] Cin;

  // Default build: MULT_PIPE=1, SATURATE=1.
  logic signed [7:0]  d_aout, d_bout;
  logic               d_vout, d_ovf;
  logic signed [15:0] d_cout;
  // Wrapping build: MULT_PIPE=1, SATURATE=0.
  logic signed [7:0]  w_aout, w_bout;
  logic               w_vout, w_ovf;
  logic signed [15:0] w_cout;
  // Combinational-multiplier build: MULT_PIPE=0, SATURATE=1.
  logic signed [7:0]  c_aout, c_bout;
  logic               c_vout, c_ovf;
  logic signed [15:0] c_cout;

  int checks = 0;
  int errors = 0;

  tpumac_pipe u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr), .vin(vin),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(d_aout), .Bout(d_bout), .vout(d_vout), .Cout(d_cout), .ovf(d_ovf)
  );

  tpumac_pipe #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr), .vin(vin),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(w_aout), .Bout(w_bout), .vout(w_vout), .Cout(w_cout), .ovf(w_ovf)
  );

  tpumac_pipe #(.MULT_PIPE(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr), .vin(vin),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(c_aout), .Bout(c_bout), .vout(c_vout), .Cout(c_cout), .ovf(c_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [7:0] a, input logic signed [7:0] b);
    vin = v;
    Ain = a;
    Bin = b;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; WrEn = 1'b0; clr = 1'b0;
    vin = 1'b0; Ain = '0; Bin = '0; Cin = '0;

    // Reset state
    #3;
    chk("rst_cout", d_cout, 0);
    chk("rst_aout", d_aout, 0);
    chk("rst_vout", d_vout, 0);
    chk("rst_ovf", d_ovf, 0);
    #9 rst_n = 1'b1;

    // Defaults: (3,4), (-5,6), (7,-2)
    drive(1, 3, 4);
    tick;                                       // edge 1
    chk("e1_aout", d_aout, 3);
    chk("e1_bout", d_bout, 4);
    chk("e1_vout", d_vout, 1);
    chk("e1_cout_pipe", d_cout, 0);
    chk("e1_cout_comb", c_cout, 12);
    drive(1, -5, 6);
    tick;                                       // edge 2
    chk("e2_aout", d_aout, -5);
    chk("e2_cout_pipe", d_cout, 12);
    chk("e2_cout_comb", c_cout, -18);
    drive(1, 7, -2);
    tick;                                       // edge 3
    chk("e3_bout", d_bout, -2);
    chk("e3_cout_pipe", d_cout, -18);
    chk("e3_cout_comb", c_cout, -32);
    drive(0, 0, 0);
    tick;                                       // edge 4
    chk("e4_vout", d_vout, 0);
    chk("e4_cout_pipe", d_cout, -32);
    chk("e4_cout_comb_bubble", c_cout, -32);
    chk("e4_ovf", d_ovf, 0);

    // Saturation / wrap: -128*-128 three times, then (1,-1)
    clr = 1'b1;
    tick;                                       // edge 5
    chk("clr_cout", d_cout, 0);
    clr = 1'b0;
    drive(1, -128, -128);
    tick;                                       // edge 6
    chk("sat_e6_cout", d_cout, 0);
    chk("sat_e6_comb", c_cout, 16384);
    tick;                                       // edge 7
    chk("sat_e7_cout", d_cout, 16384);
    chk("wrap_e7_cout", w_cout, 16384);
    chk("sat_e7_ovf", d_ovf, 0);
    chk("sat_e7_comb_clamp", c_cout, 32767);
    tick;                                       // edge 8
    chk("sat_e8_cout", d_cout, 32767);
    chk("sat_e8_ovf", d_ovf, 1);
    chk("wrap_e8_cout", w_cout, -32768);
    chk("wrap_e8_ovf", w_ovf, 1);
    drive(1, 1, -1);
    tick;                                       // edge 9
    chk("sat_e9_cout", d_cout, 32767);
    chk("sat_e9_ovf", d_ovf, 1);
    chk("wrap_e9_cout", w_cout, -16384);
    drive(0, 0, 0);
    tick;                                       // edge 10
    chk("sat_e10_cout", d_cout, 32766);
    chk("sat_e10_ovf", d_ovf, 1);
    chk("wrap_e10_cout", w_cout, -16385);

    // Preload / priority
    WrEn = 1'b1; Cin = 16'sd100;
    drive(1, 5, 10);
    tick;                                       // edge 11: C=100, P=50 in flight
    chk("wr_cout", d_cout, 100);
    chk("wr_ovf_clear", d_ovf, 0);
    chk("wr_wrap_ovf_clear", w_ovf, 0);
    Cin = -16'sd7;
    drive(0, 0, 0);
    tick;                                       // edge 12: preload wins, product dropped
    chk("wr2_cout", d_cout, -7);
    chk("wr2_ovf", d_ovf, 0);
    WrEn = 1'b0;
    tick;                                       // edge 13
    chk("wr_drop_hold", d_cout, -7);
    clr = 1'b1; WrEn = 1'b1; Cin = 16'sd55;
    tick;                                       // edge 14
    chk("clr_wins_cout", d_cout, 0);
    chk("clr_wins_comb", c_cout, 0);
    clr = 1'b0; WrEn = 1'b0; Cin = '0;

    // Enable freeze and bubbles
    drive(1, 2, 3);
    tick;                                       // edge 15: P=6
    chk("en_e15_comb", c_cout, 6);
    en = 1'b0;
    drive(1, 9, 9);
    tick;
    chk("frz1_cout", d_cout, 0);
    chk("frz1_aout", d_aout, 2);
    tick;
    tick;
    chk("frz3_cout", d_cout, 0);
    chk("frz3_bout", d_bout, 3);
    chk("frz3_vout", d_vout, 1);
    chk("frz3_comb", c_cout, 6);
    en = 1'b1;
    drive(1, 4, 5);
    tick;                                       // edge 19
    chk("res_cout", d_cout, 6);
    chk("res_comb", c_cout, 26);
    drive(0, 0, 0);
    tick;                                       // edge 20
    chk("res_cout_final", d_cout, 26);
    tick;                                       // edge 21
    chk("bubble_cout", d_cout, 26);
    chk("bubble_comb", c_cout, 26);
    chk("bubble_vout", d_vout, 0);

    // Asynchronous reset between edges
    drive(1, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cout", d_cout, 0);
    chk("arst_comb", c_cout, 0);
    chk("arst_aout", d_aout, 0);
    chk("arst_vout", d_vout, 0);
    #1 rst_n = 1'b1;
    drive(1, 3, 4);
    tick;
    chk("post_rst_pipe", d_cout, 0);
    chk("post_rst_comb", c_cout, 12);
    drive(0, 0, 0);
    tick;
    chk("post_rst_pipe2", d_cout, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
